// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encodings for the instruction-fetch stage.
// Imported by fetch_stage and fetch_pc_sel.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam int          BIOS_REGION_BIT  = 30;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux (redirect > stall > PC+4) with target word-alignment.
module fetch_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_q,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_next,
    output logic        target_misaligned
);

    always_comb begin
        pc_next = pc_q + 32'd4;
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    assign target_misaligned = |redirect_pc[1:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BIOS/IMEM read ports, region select, boot NOP.
// Optional macro FETCH_PERF_EN builds the fetch/bubble performance counters.
//
// state      | meaning
// FETCH_BOOT | after reset; NOP presented, instr_valid low
// FETCH_RUN  | memory word at pc_q presented, instr_valid high
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [BIOS_AW-1:0] bios_addr,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc_out,
    output logic               instr_valid,
    output logic               fetch_misaligned,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
);

    fetch_state_t state_q, state_next;
    logic [31:0]  pc_q, pc_next;
    logic         sel_bios_q;
    logic         misaligned_q;
    logic         target_misaligned;
    logic         stall_eff;
    logic [31:0]  instr_raw;

    // Stall is ignored in BOOT so the first fetch is always RESET_PC.
    assign stall_eff = stall && (state_q == FETCH_RUN);

    fetch_pc_sel u_pc_sel (
        .pc_q              (pc_q),
        .stall             (stall_eff),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pc_next           (pc_next),
        .target_misaligned (target_misaligned)
    );

    assign bios_addr = pc_next[BIOS_AW+1:2];
    assign imem_addr = pc_next[IMEM_AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH_BOOT;
            pc_q         <= RESET_PC - 32'd4;
            sel_bios_q   <= RESET_PC[BIOS_REGION_BIT];
            misaligned_q <= 1'b0;
        end else begin
            state_q    <= state_next;
            pc_q       <= pc_next;
            sel_bios_q <= pc_next[BIOS_REGION_BIT];
            if (redirect_valid) begin
                misaligned_q <= target_misaligned;
            end
        end
    end

    assign instr_raw = sel_bios_q ? bios_dout : imem_dout;

    always_comb begin
        state_next  = state_q;
        instr_out   = NOP_INSTR;
        instr_valid = 1'b0;
        case (state_q)
            FETCH_BOOT: begin
                state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
                instr_out   = instr_raw;
                instr_valid = 1'b1;
            end
            default: begin
                state_next = FETCH_BOOT;
            end
        endcase
    end

    assign pc_out           = pc_q;
    assign fetch_misaligned = misaligned_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else if (instr_valid && !stall) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end else begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign fetch_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with synchronous BIOS/IMEM read models.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .bios_addr        (bios_addr),
        .bios_dout        (bios_dout),
        .imem_addr        (imem_addr),
        .imem_dout        (imem_dout),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .instr_valid      (instr_valid),
        .fetch_misaligned (fetch_misaligned),
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
    );

    // BIOS word 0 holds addi x1,x0,0; other words encode their own address.
    always @(posedge clk) begin
        bios_dout <= (bios_addr == 12'd0) ? 32'h0000_0093 : (32'hB000_0000 | {20'd0, bios_addr});
        imem_dout <= 32'hA000_0000 | {18'd0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic vld);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] f, input logic [31:0] b);
`ifdef FETCH_PERF_EN
        chk({tag, ".fetch_cnt"}, fetch_count, f);
        chk({tag, ".bubble_cnt"}, bubble_count, b);
`else
        chk({tag, ".fetch_cnt"}, fetch_count, 32'd0);
        chk({tag, ".bubble_cnt"}, bubble_count, 32'd0);
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (3) step();

        chk_out("in_reset", 32'h3FFF_FFFC, 32'h0000_0013, 1'b0);
        chk("in_reset.bios_addr", {20'd0, bios_addr}, 32'h0);
        chk("in_reset.misaligned", {31'd0, fetch_misaligned}, 32'd0);
        chk_cnt("in_reset", 32'd0, 32'd0);

        // cycle 0: boot
        rst = 1'b0;
        #1;
        chk("c0.bios_addr", {20'd0, bios_addr}, 32'h0);
        chk_out("c0", 32'h3FFF_FFFC, 32'h0000_0013, 1'b0);

        step();
        chk_out("c1", 32'h4000_0000, 32'h0000_0093, 1'b1);
        step();
        chk_out("c2", 32'h4000_0004, 32'hB000_0001, 1'b1);
        step();
        chk_out("c3", 32'h4000_0008, 32'hB000_0002, 1'b1);

        stall = 1'b1;
        #1;
        chk("stall.bios_addr", {20'd0, bios_addr}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 32'h4000_0008, 32'hB000_0002, 1'b1);
            chk("stall.bios_addr_hold", {20'd0, bios_addr}, 32'h2);
        end
        stall = 1'b0;
        step();
        chk_out("resume", 32'h4000_000C, 32'hB000_0003, 1'b1);
        // bubbles: boot + 3 stall cycles; fetches: 0x..00, 0x..04, 0x..08 after stall
        chk_cnt("resume", 32'd3, 32'd4);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000_0020;
        stall          = 1'b1;
        #1;
        chk("redir.imem_addr", {18'd0, imem_addr}, 32'h8);
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk_out("redir", 32'h1000_0020, 32'hA000_0008, 1'b1);
        chk("redir.misaligned", {31'd0, fetch_misaligned}, 32'd0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000_0022;
        step();
        redirect_valid = 1'b0;
        chk_out("misal", 32'h1000_0020, 32'hA000_0008, 1'b1);
        chk("misal.flag", {31'd0, fetch_misaligned}, 32'd1);
        step();
        chk("misal.sticky", {31'd0, fetch_misaligned}, 32'd1);
        chk("misal.seq_pc", pc_out, 32'h1000_0024);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000_0040;
        step();
        redirect_valid = 1'b0;
        chk_out("realign", 32'h1000_0040, 32'hA000_0010, 1'b1);
        chk("realign.flag", {31'd0, fetch_misaligned}, 32'd0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk_out("wrap_top", 32'hFFFF_FFFC, 32'hB000_0FFF, 1'b1);
        step();
        chk_out("wrap_zero", 32'h0000_0000, 32'hA000_0000, 1'b1);

        // set the flag again so the reset clearing it is observable
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000_0041;
        step();
        redirect_valid = 1'b0;
        chk("pre_rst.flag", {31'd0, fetch_misaligned}, 32'd1);

        rst = 1'b1;
        #1;
        chk_out("mid_rst", 32'h3FFF_FFFC, 32'h0000_0013, 1'b0);
        chk("mid_rst.misaligned", {31'd0, fetch_misaligned}, 32'd0);
        chk_cnt("mid_rst", 32'd0, 32'd0);
        step();

        // stall held through boot must not block the first fetch
        rst   = 1'b0;
        stall = 1'b1;
        #1;
        chk("reboot.bios_addr", {20'd0, bios_addr}, 32'h0);
        step();
        stall = 1'b0;
        chk_out("reboot", 32'h4000_0000, 32'h0000_0093, 1'b1);
        chk_cnt("reboot", 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core. It sits directly upstream of control_decode.
- Owns the PC register and computes the next-fetch address from PC+4, redirect and stall.
- Drives the synchronous BIOS and IMEM read ports and selects the returned word by address region.
- Presents instr_out, pc_out and instr_valid to decode. NOP (addi x0,x0,0) is injected during boot.

Parameters:
- RESET_PC, 32'h4000_0000, address of the first fetch after reset (BIOS base).
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and outputs this cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  32  redirect target.
- bios_addr  out  BIOS_AW  BIOS read word address (pc_next[BIOS_AW+1:2]).
- bios_dout  in  32  BIOS read data, 1-cycle synchronous latency.
- imem_addr  out  IMEM_AW  IMEM read word address (pc_next[IMEM_AW+1:2]).
- imem_dout  in  32  IMEM read data, 1-cycle synchronous latency.
- instr_out  out  32  instruction to decode.
- pc_out  out  32  PC of instr_out.
- instr_valid  out  1  instr_out is a real fetched instruction.
- fetch_misaligned  out  1  the last redirect target had bits [1:0] != 0.
- fetch_count  out  32  retired-fetch counter (see optional feature).
- bubble_count  out  32  bubble counter (see optional feature).

Behaviour:
- Next-PC priority: redirect_valid > stall > PC+4. pc_next = {target[31:2],2'b00}, pc_q, or pc_q+4.
- PC arithmetic is 32-bit modulo, so 0xFFFF_FFFC+4 wraps to 0.
- bios_addr and imem_addr are driven combinationally from pc_next. pc_q <= pc_next every cycle. Memory data returned in cycle t is therefore the instruction at pc_q.
- Region select is registered: sel_bios_q <= pc_next[30]. instr_raw = sel_bios_q ? bios_dout : imem_dout.
- FSM states:
  - BOOT: entered on rst. instr_out = 32'h0000_0013, instr_valid = 0.
  - RUN: instr_out = instr_raw, pc_out = pc_q, instr_valid = 1.
  - BOOT -> RUN on the first clk edge after rst deasserts. RUN -> BOOT only on rst.
- Reset values:
  - pc_q = RESET_PC - 4, so pc_next = RESET_PC in the first cycle.
  - sel_bios_q = RESET_PC[30]; FSM = BOOT.
  - instr_out = NOP, pc_out = RESET_PC - 4, instr_valid = 0, fetch_misaligned = 0, counters = 0.
- Stall: pc_q is held and the same address is re-read, so instr_out and pc_out are stable across the whole stall. Stall during BOOT has no effect (BOOT still exits).
- Redirect together with stall: redirect wins. The target is fetched and appears on the next cycle.
- The instruction present on the redirect cycle is squashed by downstream. Fetch does not bubble.
- fetch_misaligned is registered. It is set on a redirect whose target[1:0] != 0 and cleared by the next redirect with aligned bits. The target is always word-aligned before use.
- Reset mid-operation: all state returns to its reset value immediately (asynchronous reset). The first fetch after rst deasserts is RESET_PC.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - fetch_count increments on every cycle with instr_valid=1 and stall=0.
  - bubble_count increments on every cycle with instr_valid=0 or stall=1.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter flops are built.

Decomposition:
- Shared package/header (alongside opcode.vh) holds NOP_INSTR = 32'h0000_0013, RESET_PC default, the BIOS region bit index (30), and the FSM state encodings FETCH_BOOT and FETCH_RUN.
- One sub-module, fetch_pc_sel: combinational next-PC priority mux plus alignment. Everything else stays in fetch_stage.

Test Plan:
- Reset release, BIOS returns 0x0000_0093 at 0x4000_0000:
  - Cycle 0: bios_addr = 0x000, instr_valid = 0, instr_out = 0x13.
  - Cycle 1: instr_out = 0x0000_0093, pc_out = 0x4000_0000, valid = 1.
- Straight-line run of 4 cycles: pc_out = 0x4000_0000, _0004, _0008, _000C.
- Stall for 3 cycles at pc 0x4000_0008: pc_out and instr_out hold. bios_addr stays 0x002. Sequential fetch resumes at 0x4000_000C.
- Redirect to 0x1000_0020 with stall=1 in the same cycle: imem_addr = 0x008. Next cycle pc_out = 0x1000_0020, instr_out = imem_dout (IMEM selected).
- Redirect to 0x1000_0022: fetch_misaligned = 1 and pc_out = 0x1000_0020. A later redirect to 0x1000_0040 clears the flag.
- rst asserted mid-run at pc 0x1000_0040: outputs reset immediately. After release, first fetch is 0x4000_0000. With FETCH_PERF_EN, the counters read 0.
